mobo_bus_arbiter: RTL and testbench
===================================

# mobo_bus_arbiter

Round-robin arbiter and sequencer for the single motherboard read/write port (`mobo_ctrl` / `mobo_stat`). It sits between the CPU-side requesters (instruction fetch, data access, debug port) and the motherboard. It grants one requester at a time and runs the IDLE → CTRL_READ/CTRL_WRITE → DONE → CTRL_NONE handshake on that requester's behalf. The requester gets back a one-cycle acknowledge and, for reads, the read data.

## Interface

**Parameters**
- `WORD_WIDTH`, default 32: data, address and ctrl/stat word width.
- `NUM_REQ`, default 3: number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only with `MOBO_ARB_TIMEOUT_EN`.

**Ports**
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, NUM_REQ: per-requester transaction request, level.
- `req_we`, in, NUM_REQ: 1 = write, 0 = read; per requester.
- `req_addr`, in, NUM_REQ*WORD_WIDTH: packed addresses; requester i at slice i.
- `req_wdata`, in, NUM_REQ*WORD_WIDTH: packed write data.
- `ack`, out, NUM_REQ: one-hot, one-cycle completion pulse.
- `err`, out, NUM_REQ: one-cycle error pulse (timeout only); coincident with `ack`.
- `rdata`, out, WORD_WIDTH: read data, valid in the `ack` cycle; holds until the next read completes.
- `mobo_ctrl`, out, WORD_WIDTH: CTRL_NONE / CTRL_READ / CTRL_WRITE.
- `mobo_stat`, in, WORD_WIDTH: STAT_IDLE / STAT_DONE / other = busy.
- `mobo_addr`, out, WORD_WIDTH: latched address of the granted requester.
- `mobo_wdata`, out, WORD_WIDTH: latched write data.
- `mobo_rdata`, in, WORD_WIDTH: motherboard read data, sampled when `mobo_stat` == STAT_DONE.

## Operation

- **All outputs are registered.** Reset values: `mobo_ctrl`=CTRL_NONE, `ack`=0, `err`=0, `rdata`=0, `mobo_addr`=0, `mobo_wdata`=0, state=ARB, round-robin pointer=0.
- **ARB**
  - If any `req` bit is set, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's addr/wdata/we into `mobo_addr`/`mobo_wdata`/internal `we`.
  - Set the pointer to grant+1 (wrapping) and go to ISSUE.
  - Otherwise stay in ARB.
- **ISSUE**
  - When `mobo_stat`==STAT_IDLE, drive `mobo_ctrl` = we ? CTRL_WRITE : CTRL_READ and go to WAIT.
  - Otherwise hold CTRL_NONE and stay.
- **WAIT**
  - Hold `mobo_ctrl` until `mobo_stat`==STAT_DONE.
  - On DONE: `mobo_ctrl`←CTRL_NONE; `ack[grant]`←1 for one cycle; if read, `rdata`←`mobo_rdata`; go to DRAIN.
- **DRAIN:** wait for `mobo_stat`==STAT_IDLE, then go to ARB. This stops a stale DONE from being taken as a second completion.
- **Requesters**
  - Operands are latched at grant, so they need not be held after the grant.
  - Dropping `req` after the grant does not abort the transaction; the `ack` still pulses.
  - A requester that keeps `req` high after `ack` re-enters arbitration behind the others (fairness).
- **Simultaneous requests:** resolved strictly round-robin; no priority input.
- **Reset mid-transaction:** all outputs return to their reset values immediately (asynchronously), no `ack` is issued, and the pointer returns to 0.

## Timing

- `req` is sampled at edge N (state ARB).
- `mobo_ctrl` is valid after edge N+1 if `mobo_stat` is IDLE at that edge.
- `ack` goes high after the edge where STAT_DONE is seen (the WAIT→DRAIN edge), for exactly one cycle.
- Minimum `req`→`ack` latency, with DONE returned the cycle after ctrl: 3 cycles.
- Minimum time between back-to-back grants: 4 cycles (ARB, ISSUE, WAIT, DRAIN).
- `mobo_addr`/`mobo_wdata` are stable from ISSUE through DRAIN.

## Configuration

- `MOBO_ARB_TIMEOUT_EN` defined:
  - A counter runs in ISSUE and WAIT.
  - When it reaches TIMEOUT_CYCLES: `mobo_ctrl`←CTRL_NONE, `ack[grant]` and `err[grant]` pulse together, `rdata` is unchanged, and the state goes to DRAIN.
- Undefined: no counter; `err` is tied to 0; ISSUE/WAIT may wait indefinitely.

## Structure

- **Shared package:** CTRL_NONE/READ/WRITE and STAT_IDLE/DONE (moved from the global constants), the `WORD_WIDTH` default, and the arbiter state enum (ARB, ISSUE, WAIT, DRAIN).
- **Sub-module `rr_pick`:** combinational round-robin selector taking `req` and the pointer, returning a one-hot grant and a valid flag. It is reusable by other shared-resource arbiters.

## Test plan

- **Single read:** req=001, addr0=0x100, stat IDLE then DONE one cycle after CTRL_READ with mobo_rdata=0xDEADBEEF → ack=001 for one cycle; rdata=0xDEADBEEF; mobo_ctrl returns to CTRL_NONE.
- **Contention:** req=111 held → acks in order 001, 010, 100, 001; each write from requester 1 shows `mobo_wdata` = wdata1.
- **Busy motherboard:** stat held busy for 5 cycles in ISSUE → mobo_ctrl stays CTRL_NONE until stat=IDLE; exactly one ack.
- **Stale DONE:** stat held at DONE for 3 cycles after completion → exactly one ack; the next grant waits for IDLE.
- **Reset mid-transaction:** rst asserted in WAIT → mobo_ctrl=CTRL_NONE with no clock edge; ack=0; the next transaction is granted to requester 0.
- **Timeout (`MOBO_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16):** DONE never arrives → ack and err pulse for the granted requester 16 cycles after ISSUE entry; rdata unchanged.

Source files
------------

// File: rtl/mobo_bus_arbiter_pkg.sv
// Shared definitions for the motherboard bus arbiter: control/status
// encodings, default word width and the arbiter state enum.
package mobo_bus_arbiter_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  localparam logic [31:0] CTRL_NONE  = 32'd0;
  localparam logic [31:0] CTRL_READ  = 32'd1;
  localparam logic [31:0] CTRL_WRITE = 32'd2;

  localparam logic [31:0] STAT_IDLE  = 32'd0;
  localparam logic [31:0] STAT_DONE  = 32'd1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mobo_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: returns a one-hot grant for the first
// set request at or after the pointer, wrapping around, plus a valid flag.
// Generic so other shared-resource arbiters can reuse it.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Scan offsets from the pointer upward and keep only the first hit
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid && req[i] && (i == ((int'(ptr) + off) % N))) begin
          grant[i] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mobo_bus_arbiter.sv
// Round-robin arbiter and sequencer for the single motherboard read/write
// port. Grants one requester at a time, runs the ctrl/stat handshake for it
// and returns a one-cycle ack plus read data.
// Optional watchdog: define MOBO_ARB_TIMEOUT_EN to abort a transaction that
// sits in ISSUE/WAIT for TIMEOUT_CYCLES cycles (ack and err pulse together).
module mobo_bus_arbiter
  import mobo_bus_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic [WORD_WIDTH-1:0]         rdata,
  output logic [WORD_WIDTH-1:0]         mobo_ctrl,
  input  logic [WORD_WIDTH-1:0]         mobo_stat,
  output logic [WORD_WIDTH-1:0]         mobo_addr,
  output logic [WORD_WIDTH-1:0]         mobo_wdata,
  input  logic [WORD_WIDTH-1:0]         mobo_rdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [WORD_WIDTH-1:0] C_NONE  = WORD_WIDTH'(CTRL_NONE);
  localparam logic [WORD_WIDTH-1:0] C_READ  = WORD_WIDTH'(CTRL_READ);
  localparam logic [WORD_WIDTH-1:0] C_WRITE = WORD_WIDTH'(CTRL_WRITE);
  localparam logic [WORD_WIDTH-1:0] S_IDLE  = WORD_WIDTH'(STAT_IDLE);
  localparam logic [WORD_WIDTH-1:0] S_DONE  = WORD_WIDTH'(STAT_DONE);

  arb_state_t              state, state_next;
  logic [PTR_W-1:0]        ptr, ptr_next, pick_idx, grant_idx;
  logic [NUM_REQ-1:0]      pick_grant, ack_next;
  logic                    pick_valid, we, finish, rdata_load, timeout_hit;
  logic [WORD_WIDTH-1:0]   ctrl_next;
  logic                    stat_idle, stat_done;

  assign stat_idle = (mobo_stat == S_IDLE);
  assign stat_done = (mobo_stat == S_DONE);

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Convert the one-hot pick into an index for operand muxing and the pointer
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_idx = PTR_W'(i);
    end
  end

  assign ptr_next = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);

`ifdef MOBO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   to_cnt;
  logic [NUM_REQ-1:0] err_next;

  assign timeout_hit = ((state == ISSUE) || (state == WAIT)) &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: zero on ISSUE entry, counts every cycle spent in ISSUE or WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 to_cnt <= '0;
    else if (state == ISSUE || state == WAIT) to_cnt <= to_cnt + CNT_W'(1);
    else                                     to_cnt <= '0;
  end

  // Error pulse rides alongside the ack of an aborted transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= '0;
    else     err <= err_next;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_next;
  end

  // Next-state logic; DRAIN waits for IDLE so a lingering DONE is not reused
  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (pick_valid) state_next = ISSUE;
      ISSUE:   if (timeout_hit) state_next = DRAIN;
               else if (stat_idle) state_next = WAIT;
      WAIT:    if (stat_done || timeout_hit) state_next = DRAIN;
      DRAIN:   if (stat_idle) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Output decode: next ctrl word, completion/abort and read-data capture
  always_comb begin
    ctrl_next  = mobo_ctrl;
    finish     = 1'b0;
    ack_next   = '0;
    rdata_load = 1'b0;
`ifdef MOBO_ARB_TIMEOUT_EN
    err_next   = '0;
`endif
    case (state)
      ISSUE: begin
        if (timeout_hit) begin
          ctrl_next = C_NONE;
          finish    = 1'b1;
`ifdef MOBO_ARB_TIMEOUT_EN
          err_next  = NUM_REQ'(1) << grant_idx;
`endif
        end else if (stat_idle) begin
          ctrl_next = we ? C_WRITE : C_READ;
        end
      end
      WAIT: begin
        if (stat_done) begin
          ctrl_next  = C_NONE;
          finish     = 1'b1;
          rdata_load = !we;
        end else if (timeout_hit) begin
          ctrl_next = C_NONE;
          finish    = 1'b1;
`ifdef MOBO_ARB_TIMEOUT_EN
          err_next  = NUM_REQ'(1) << grant_idx;
`endif
        end
      end
      default: ;
    endcase
    if (finish) ack_next = NUM_REQ'(1) << grant_idx;
  end

  // Registered outputs, grant bookkeeping and operand latching at grant time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mobo_ctrl  <= C_NONE;
      ack        <= '0;
      rdata      <= '0;
      mobo_addr  <= '0;
      mobo_wdata <= '0;
      we         <= 1'b0;
      grant_idx  <= '0;
      ptr        <= '0;
    end else begin
      mobo_ctrl <= ctrl_next;
      ack       <= ack_next;
      if (rdata_load) rdata <= mobo_rdata;
      if (state == ARB && pick_valid) begin
        mobo_addr  <= req_addr[pick_idx*WORD_WIDTH +: WORD_WIDTH];
        mobo_wdata <= req_wdata[pick_idx*WORD_WIDTH +: WORD_WIDTH];
        we         <= req_we[pick_idx];
        grant_idx  <= pick_idx;
        ptr        <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_mobo_bus_arbiter.sv
// Self-checking bench for mobo_bus_arbiter: a motherboard model answers the
// ctrl handshake, expected completions sit in a scoreboard queue and are
// compared as acks appear.
module tb_mobo_bus_arbiter;
  import mobo_bus_arbiter_pkg::*;

  localparam logic [31:0] STAT_BUSY = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_we, ack, err;
  logic [95:0] req_addr, req_wdata;
  logic [31:0] rdata, mobo_ctrl, mobo_stat, mobo_addr, mobo_wdata, mobo_rdata;

  typedef struct {
    logic [2:0]  ack;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t        sb[$];
  int          ack_times[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] last_rd = '0;

  int          busy_left = 0;
  int          stale_left = 0;
  int          stale_cfg = 0;
  bit          never_done = 1'b0;
  bit          issue_evt = 1'b0;
  logic [31:0] prev_ctrl = CTRL_NONE;
  logic [31:0] edge_stat = STAT_IDLE;

  mobo_bus_arbiter #(.WORD_WIDTH(32), .NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .mobo_ctrl  (mobo_ctrl),
    .mobo_stat  (mobo_stat),
    .mobo_addr  (mobo_addr),
    .mobo_wdata (mobo_wdata),
    .mobo_rdata (mobo_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic set_op(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_we[idx]            = w;
    req_addr[idx*32 +: 32]  = a;
    req_wdata[idx*32 +: 32] = d;
  endtask

  task automatic push_txn(input int idx, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic e);
    txn_t t;
    t.ack   = 3'b001 << idx;
    t.we    = w;
    t.addr  = a;
    t.wdata = d;
    t.err   = e;
    if (!w && !e) last_rd = rd_fn(a);
    t.rdata = last_rd;
    sb.push_back(t);
  endtask

  // One clock: motherboard model reacts after the edge, checks at the negedge
  task automatic tick();
    txn_t t;
    @(posedge clk);
    cyc++;
    #2;
    edge_stat = mobo_stat;
    issue_evt = (mobo_ctrl != CTRL_NONE) && (prev_ctrl == CTRL_NONE);
    prev_ctrl = mobo_ctrl;
    if (busy_left > 0) begin
      mobo_stat = STAT_BUSY;
      busy_left--;
    end else if (mobo_ctrl != CTRL_NONE) begin
      if (never_done) mobo_stat = STAT_BUSY;
      else begin
        mobo_stat  = STAT_DONE;
        stale_left = stale_cfg;
        mobo_rdata = rd_fn(mobo_addr);
      end
    end else if (mobo_stat == STAT_DONE && stale_left > 0) begin
      stale_left--;
    end else begin
      mobo_stat = STAT_IDLE;
    end
    @(negedge clk);
    if (issue_evt) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_issue: ctrl %h with nothing outstanding", mobo_ctrl);
      end else begin
        t = sb[0];
        if (edge_stat !== STAT_IDLE) begin
          miscompares++;
          $display("[TB] FAIL issue_stat: stat at issue %h, required %h", edge_stat, STAT_IDLE);
        end
        vectors++;
        if (mobo_ctrl !== (t.we ? CTRL_WRITE : CTRL_READ)) begin
          miscompares++;
          $display("[TB] FAIL issue_ctrl: got %h, required %h", mobo_ctrl, t.we ? CTRL_WRITE : CTRL_READ);
        end
        vectors++;
        if (mobo_addr !== t.addr) begin
          miscompares++;
          $display("[TB] FAIL issue_addr: got %h, required %h", mobo_addr, t.addr);
        end
        if (t.we) begin
          vectors++;
          if (mobo_wdata !== t.wdata) begin
            miscompares++;
            $display("[TB] FAIL issue_wdata: got %h, required %h", mobo_wdata, t.wdata);
          end
        end
      end
    end
    if (ack !== 3'b000) begin
      ack_times.push_back(cyc);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_ack: ack %b with nothing outstanding", ack);
      end else begin
        t = sb.pop_front();
        if (ack !== t.ack) begin
          miscompares++;
          $display("[TB] FAIL ack: got %b, required %b", ack, t.ack);
        end
        vectors++;
        if (err !== (t.err ? t.ack : 3'b000)) begin
          miscompares++;
          $display("[TB] FAIL err: got %b, required %b", err, t.err ? t.ack : 3'b000);
        end
        vectors++;
        if (rdata !== t.rdata) begin
          miscompares++;
          $display("[TB] FAIL rdata: got %h, required %h", rdata, t.rdata);
        end
      end
    end
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ack_timeout: %0d acks outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (mobo_ctrl !== CTRL_NONE) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %h, required %h", mobo_ctrl, CTRL_NONE); end
    vectors++; if (ack !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_ack: got %b, required 000", ack); end
    vectors++; if (err !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_err: got %b, required 000", err); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h, required 0", rdata); end
    vectors++; if (mobo_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h, required 0", mobo_addr); end
    vectors++; if (mobo_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h, required 0", mobo_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int t0;
    set_op(0, 1'b0, 32'h100, 32'h0);
    push_txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
    t0 = cyc;
    req = 3'b001;
    tick();
    req = 3'b000;
    wait_empty(40);
    vectors++;
    if (ack_times.size() == 0 || ack_times[ack_times.size()-1] - t0 != 3) begin
      miscompares++;
      $display("[TB] FAIL read_latency: got %0d, required 3", ack_times.size() == 0 ? -1 : ack_times[ack_times.size()-1] - t0);
    end
    vectors++;
    if (mobo_ctrl !== CTRL_NONE) begin miscompares++; $display("[TB] FAIL read_ctrl_release: got %h, required %h", mobo_ctrl, CTRL_NONE); end
    tick();
    vectors++;
    if (ack !== 3'b000) begin miscompares++; $display("[TB] FAIL ack_width: got %b, required 000", ack); end
    repeat (3) tick();
  endtask

  task automatic test_contention();
    int n0;
    do_reset();
    set_op(0, 1'b0, 32'h200, 32'h0);
    set_op(1, 1'b1, 32'h300, 32'hCAFE_0001);
    set_op(2, 1'b0, 32'h400, 32'h0);
    push_txn(0, 1'b0, 32'h200, 32'h0, 1'b0);
    push_txn(1, 1'b1, 32'h300, 32'hCAFE_0001, 1'b0);
    push_txn(2, 1'b0, 32'h400, 32'h0, 1'b0);
    push_txn(0, 1'b0, 32'h200, 32'h0, 1'b0);
    n0 = ack_times.size();
    req = 3'b111;
    wait_empty(100);
    req = 3'b000;
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (ack_times.size() < n0 + 4 || ack_times[n0+i] - ack_times[n0+i-1] != 4) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_gap%0d: got %0d, required 4", i,
                 ack_times.size() < n0 + 4 ? -1 : ack_times[n0+i] - ack_times[n0+i-1]);
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_busy();
    int t0;
    int n0;
    set_op(0, 1'b0, 32'h0A0, 32'h0);
    push_txn(0, 1'b0, 32'h0A0, 32'h0, 1'b0);
    busy_left = 5;
    n0 = ack_times.size();
    t0 = cyc;
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (mobo_ctrl !== CTRL_NONE) begin
        miscompares++;
        $display("[TB] FAIL busy_ctrl%0d: got %h, required %h", i, mobo_ctrl, CTRL_NONE);
      end
    end
    wait_empty(40);
    repeat (4) tick();
    vectors++;
    if (ack_times.size() != n0 + 1 || ack_times[n0] - t0 != 8) begin
      miscompares++;
      $display("[TB] FAIL busy_acks: got %0d acks, required 1 at latency 8", ack_times.size() - n0);
    end
  endtask

  task automatic test_stale_done();
    int n0;
    stale_cfg = 3;
    set_op(1, 1'b0, 32'h500, 32'h0);
    push_txn(1, 1'b0, 32'h500, 32'h0, 1'b0);
    push_txn(1, 1'b0, 32'h500, 32'h0, 1'b0);
    n0 = ack_times.size();
    req = 3'b010;
    wait_empty(100);
    req = 3'b000;
    repeat (8) tick();
    stale_cfg = 0;
    vectors++;
    if (ack_times.size() != n0 + 2 || ack_times[n0+1] - ack_times[n0] != 7) begin
      miscompares++;
      $display("[TB] FAIL stale_done: got %0d acks, required 2 spaced 7 cycles", ack_times.size() - n0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    never_done = 1'b1;
    set_op(1, 1'b0, 32'h600, 32'h0);
    push_txn(1, 1'b0, 32'h600, 32'h0, 1'b0);
    req = 3'b010;
    tick();
    req = 3'b000;
    while (mobo_ctrl != CTRL_READ && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (mobo_ctrl !== CTRL_READ) begin miscompares++; $display("[TB] FAIL mid_reach_wait: got %h, required %h", mobo_ctrl, CTRL_READ); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (mobo_ctrl !== CTRL_NONE) begin miscompares++; $display("[TB] FAIL mid_reset_ctrl: got %h, required %h", mobo_ctrl, CTRL_NONE); end
    vectors++; if (ack !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_reset_ack: got %b, required 000", ack); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_rdata: got %h, required 0", rdata); end
    vectors++; if (mobo_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_reset_addr: got %h, required 0", mobo_addr); end
    sb.delete();
    never_done = 1'b0;
    busy_left  = 0;
    last_rd    = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    set_op(0, 1'b0, 32'h700, 32'h0);
    set_op(2, 1'b1, 32'h800, 32'h1234_ABCD);
    push_txn(0, 1'b0, 32'h700, 32'h0, 1'b0);
    push_txn(2, 1'b1, 32'h800, 32'h1234_ABCD, 1'b0);
    req = 3'b101;
    wait_empty(60);
    req = 3'b000;
    repeat (4) tick();
  endtask

`ifdef MOBO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    never_done = 1'b1;
    set_op(0, 1'b0, 32'h900, 32'h0);
    push_txn(0, 1'b0, 32'h900, 32'h0, 1'b1);
    t0 = cyc;
    req = 3'b001;
    tick();
    req = 3'b000;
    wait_empty(60);
    never_done = 1'b0;
    vectors++;
    if (ack_times.size() == 0 || ack_times[ack_times.size()-1] - t0 != 17) begin
      miscompares++;
      $display("[TB] FAIL timeout_latency: got %0d, required 17",
               ack_times.size() == 0 ? -1 : ack_times[ack_times.size()-1] - t0);
    end
    repeat (4) tick();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mobo_stat  = STAT_IDLE;
    mobo_rdata = '0;
    $display("[TB] starting mobo_bus_arbiter bench");
    test_reset();
    test_single_read();
    test_contention();
    test_busy();
    test_stale_done();
    test_reset_mid();
`ifdef MOBO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
